// File: rtl/da_rom_fir_serial.sv
// da_rom_fir_serial: 4-tap symmetric low-pass FIR, bit-serial LSB-first input, distributed-arithmetic ROM engine
// Ports:
//   clock    rising-edge system clock
//   i_reset  asynchronous active-low reset
//   i_enable clock enable, all state holds while low
//   i_data   serial sample bit, LSB first, NB_DATA_IN bits per sample
//   o_data   signed full-precision filter output, updated once per frame
module da_rom_fir_serial #(
  parameter int NB_DATA_IN  = 8,
  parameter int NB_COEFF    = 16,
  parameter int NB_DATA_OUT = 28
) (
  input  logic                          clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_data,
  output logic signed [NB_DATA_OUT-1:0] o_data
);
  localparam int NB_CNT = $clog2(NB_DATA_IN);
  localparam logic signed [NB_COEFF-1:0] H0 = 1024;
  localparam logic signed [NB_COEFF-1:0] H1 = 7168;
  localparam logic signed [NB_COEFF-1:0] H2 = 7168;
  localparam logic signed [NB_COEFF-1:0] H3 = 1024;
  logic        [NB_CNT-1:0]      r_cnt;
  logic        [NB_DATA_IN-2:0]  r_sr;
  logic signed [NB_DATA_IN-1:0]  r_x [4];
  logic signed [NB_DATA_OUT-1:0] r_acc;
  logic signed [NB_DATA_OUT-1:0] w_rom;
  logic signed [NB_DATA_OUT-1:0] w_rom_sh;
  logic signed [NB_DATA_OUT-1:0] w_sum;
  logic        [3:0]             w_addr;
  logic                          w_last;
  assign w_last = r_cnt == NB_CNT'(NB_DATA_IN - 1);
  // DA works on the taps loaded at the previous frame boundary, one bit slice per cycle
  always_comb begin
    w_addr = '0;
    for (int k = 0; k < 4; k++) w_addr[k] = r_x[k][r_cnt];
  end
  // Coefficient-sum ROM: sum of h_k for every set address bit
  always_comb begin
    w_rom = (w_addr[0] ? NB_DATA_OUT'(H0) : NB_DATA_OUT'(0))
          + (w_addr[1] ? NB_DATA_OUT'(H1) : NB_DATA_OUT'(0))
          + (w_addr[2] ? NB_DATA_OUT'(H2) : NB_DATA_OUT'(0))
          + (w_addr[3] ? NB_DATA_OUT'(H3) : NB_DATA_OUT'(0));
    w_rom_sh = w_rom << r_cnt;
    w_sum    = (r_cnt == '0) ? w_rom_sh : r_acc + w_rom_sh;
  end
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_sr   <= '0;
      r_x    <= '{default: '0};
      r_acc  <= '0;
      o_data <= '0;
    end else if (i_enable) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      r_acc <= w_sum;
      r_sr  <= {i_data, r_sr[NB_DATA_IN-2:1]};
      if (w_last) begin
        // Sign-bit slice carries negative weight in two's complement
        o_data <= r_acc - w_rom_sh;
        r_x[0] <= {i_data, r_sr};
        r_x[1] <= r_x[0];
        r_x[2] <= r_x[1];
        r_x[3] <= r_x[2];
      end
    end
  end
endmodule

// File: tb/tb_da_rom_fir_serial.sv
// tb_da_rom_fir_serial: randomized self-checking bench against an arithmetic FIR model
module tb_da_rom_fir_serial;
  localparam int NO = 28;
  logic clock = 0;
  logic i_reset = 0;
  logic i_enable = 0;
  logic i_data = 0;
  logic signed [NO-1:0] o_data;
  int n_tests = 0;
  int n_fail = 0;
  int hist [4] = '{0, 0, 0, 0};
  int coef [4] = '{1024, 7168, 7168, 1024};
  int exp_out = 0;

  da_rom_fir_serial dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_data(i_data), .o_data(o_data)
  );

  always #5 clock = ~clock;

  function automatic int fir_y();
    int s = 0;
    for (int k = 0; k < 4; k++) s += coef[k] * hist[k];
    return s;
  endfunction

  task automatic model_reset();
    hist = '{0, 0, 0, 0};
    exp_out = 0;
  endtask

  // Sends one sample; optional enable gap of gap_len cycles before bit gap_at
  task automatic send_sample(input logic [7:0] s, input int gap_at = -1, input int gap_len = 0);
    for (int b = 0; b < 8; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clock);
          i_enable = 0;
          i_data = ~i_data;
          @(posedge clock);
          #1;
          n_tests++;
          if (o_data !== NO'(exp_out)) begin
            n_fail++;
            $display("FAIL gap_hold: o_data=%0d expected %0d", o_data, exp_out);
          end
        end
      end
      @(negedge clock);
      i_data = s[b];
      i_enable = 1;
      @(posedge clock);
      #1;
      if (b == 7) begin
        exp_out = fir_y();
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = int'($signed(s));
      end
      n_tests++;
      if (o_data !== NO'(exp_out)) begin
        n_fail++;
        $display("FAIL stream bit %0d sample %02h: o_data=%0d expected %0d", b, s, o_data, exp_out);
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 0;
    repeat (10) @(posedge clock);
    #1;
    n_tests++;
    if (o_data !== '0) begin
      n_fail++;
      $display("FAIL reset_value: o_data=%0d expected 0", o_data);
    end
    @(negedge clock);
    i_reset = 1;
    model_reset();
    repeat (5) send_sample(8'h00);
  endtask

  task automatic test_impulse(input logic [7:0] s, input int w0, input int w1, input int w2, input int w3);
    int want [5];
    want = '{w0, w1, w2, w3, 0};
    send_sample(s);
    for (int i = 0; i < 5; i++) begin
      send_sample(8'h00);
      n_tests++;
      if (o_data !== NO'(want[i])) begin
        n_fail++;
        $display("FAIL impulse_%02h frame %0d: o_data=%0d expected %0d", s, i, o_data, want[i]);
      end
    end
  endtask

  task automatic test_dc(input logic [7:0] s, input int settled);
    repeat (6) send_sample(s);
    n_tests++;
    if (o_data !== NO'(settled)) begin
      n_fail++;
      $display("FAIL dc_%02h: o_data=%0d expected %0d", s, o_data, settled);
    end
  endtask

  task automatic test_alternating();
    repeat (6) begin
      send_sample(8'h7F);
      send_sample(8'h80);
    end
  endtask

  task automatic test_enable_gap();
    send_sample(8'h01, 3, 5);
    for (int i = 0; i < 5; i++) send_sample(8'h00, (i == 1) ? 5 : -1, 5);
  endtask

  task automatic test_random();
    repeat (30) send_sample(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] junk;
    send_sample(8'h7F);
    send_sample(8'h7F);
    junk = 8'($urandom_range(0, 255));
    for (int b = 0; b < 3; b++) begin
      @(negedge clock);
      i_data = junk[b];
      i_enable = 1;
    end
    @(posedge clock);
    #2;
    i_reset = 0;
    #1;
    n_tests++;
    if (o_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: o_data=%0d expected 0", o_data);
    end
    model_reset();
    @(negedge clock);
    i_enable = 0;
    @(negedge clock);
    i_reset = 1;
    send_sample(8'h01);
    repeat (6) send_sample(8'($urandom_range(0, 255)));
  endtask

  initial begin
    test_reset();
    test_impulse(8'h01, 1024, 7168, 7168, 1024);
    test_impulse(8'h80, -131072, -917504, -917504, -131072);
    test_dc(8'h7F, 2080768);
    test_dc(8'h80, -2097152);
    test_alternating();
    test_enable_gap();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
